fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction queue between the fetch stage and the decoder. Accepts one fetched packet per cycle (instruction word, PC, branch-guess flag, predicted next PC), holds up to DEPTH packets in order, and presents the oldest packet to the decoder. A flush discards everything. Flush sources are a decoder redirect (`o_branch_inconsistency`) or a back-end mispredict.

## Interface
- DEPTH, 8: entries; power of two, ≥2
- ADDR_WIDTH, `ADDR_WIDTH: PC/prediction width

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_flush  in  1  discard all entries and the incoming packet
- i_valid  in  1  fetch presents a packet
- i_instr  in  32  instruction word
- i_pc  in  ADDR_WIDTH  instruction PC
- i_guesses_branch  in  1  predictor redirected after this instruction
- i_prediction  in  ADDR_WIDTH  predicted next PC
- o_ready  out  1  buffer can accept this cycle
- o_valid  out  1  oldest packet valid toward decoder
- o_instr  out  32  oldest instruction
- o_pc  out  ADDR_WIDTH  oldest PC
- o_guesses_branch  out  1  oldest guess flag
- o_prediction  out  ADDR_WIDTH  oldest prediction
- i_ready  in  1  decoder consumes the presented packet
- o_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH-entry circular array, rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, count register of $clog2(DEPTH)+1 bits.
- Enqueue: `enq = i_valid & o_ready`. It writes array[wr_ptr] and advances wr_ptr.
- Dequeue: `deq = o_valid & i_ready`. It advances rd_ptr.
- Count update: +1 on enq only, −1 on deq only, unchanged on both.
- `o_ready = (count != DEPTH) & ~i_flush`.
  - Full blocks enqueue even when a dequeue occurs the same cycle. This is deliberate, to keep the ready path short.
- `o_valid = (count != 0) & ~i_flush`. The o_* data fields are array[rd_ptr].
- Flush: on a clock edge with i_flush high, rd_ptr, wr_ptr and count go to 0. No write happens and no dequeue is counted. The incoming packet is dropped, and fetch must re-present from the redirect PC.
- Reset: on an edge with reset high, pointers and count go to 0. Array contents are not reset.
- Outputs after reset: o_valid=0, o_ready=1, o_count=0.
- Reset has priority over flush, and flush over enq/deq. A reset or flush in the middle of a burst loses all held packets.
- Data fields with o_valid=0 are don't-care.

## Timing
- Without bypass, latency is 1 cycle. A packet enqueued at edge N is presented (o_valid=1) in cycle N+1.
- Throughput is 1 packet/cycle when not full. Sustained streaming with i_ready=1 holds count steady.
- Handshake on both sides is valid/ready, sampled at the rising edge. The presented packet and o_valid stay stable until consumed or flushed.
- o_ready and o_valid depend combinationally only on count and i_flush, never on i_ready or i_valid (no bypass).
- Wrap-around: after DEPTH enqueues, wr_ptr returns to 0. Order is preserved across the wrap.

## Configuration
- FETCH_BUFFER_BYPASS_EN.
- Defined:
  - When count==0, i_valid=1 and i_flush=0, then o_valid=1 the same cycle and the o_* fields equal the i_* fields.
  - If i_ready=1 in that cycle, the packet is consumed directly: not written, pointers and count unchanged.
  - If i_ready=0, it is enqueued normally.
  - Latency drops to 0 cycles when empty.
- Undefined: behaviour as above with 1-cycle latency and no combinational in→out path.

## Structure
- Shared package `riscv_core` gains `fetch_packet_t` (packed struct: instr[31:0], pc, guesses_branch, prediction) and `FETCH_BUFFER_DEPTH` = 8. The array is stored as `fetch_packet_t`.
- Single module, no sub-module. The storage is an inferred register array.

## Test plan
- Reset, then push instr 0x00500093 at PC 0x100 with i_ready=0 → next cycle: o_valid=1, o_pc=0x100, o_count=1. With bypass: o_valid=1 in the push cycle.
- Push 8 packets (PC 0x0..0x1C) with i_ready=0 → o_count=8, o_ready=0. A 9th push with i_valid=1 is ignored. Then drain with i_ready=1 → PCs 0x0..0x1C in order, o_count=0.
- Fill to 8, then i_valid=1 and i_ready=1 for one cycle → one dequeue, no enqueue, count=7. Next cycle o_ready=1.
- Continuous stream of 20 packets with i_ready=1 → all 20 delivered in order across pointer wrap, none lost. Count ≤1 without bypass, 0 with bypass.
- Hold 3 entries, assert i_flush with i_valid=1 (PC 0x40) → o_valid=0 and o_ready=0 that cycle. Next cycle: count=0, PC 0x40 absent.
- Assert reset for one cycle in the middle of a burst with 5 entries held → next cycle o_valid=0, o_ready=1, o_count=0. The first post-reset push is delivered correctly.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared core package: fetch packet layout and fetch buffer sizing.
// ADDR_WIDTH may be overridden at build time with +define+ADDR_WIDTH=<n>.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_core;

    localparam int FETCH_ADDR_WIDTH   = `ADDR_WIDTH;
    localparam int FETCH_BUFFER_DEPTH = 8;

    typedef struct packed {
        logic [31:0]                 instr;
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic                        guesses_branch;
        logic [FETCH_ADDR_WIDTH-1:0] prediction;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction queue between fetch and decode, flushable on redirect.
// Optional same-cycle pass-through when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
    import riscv_core::*;
#(
    parameter int DEPTH      = FETCH_BUFFER_DEPTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [31:0]              i_instr,
    input  logic [ADDR_WIDTH-1:0]    i_pc,
    input  logic                     i_guesses_branch,
    input  logic [ADDR_WIDTH-1:0]    i_prediction,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [31:0]              o_instr,
    output logic [ADDR_WIDTH-1:0]    o_pc,
    output logic                     o_guesses_branch,
    output logic [ADDR_WIDTH-1:0]    o_prediction,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_packet_t          mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    fetch_packet_t          in_pkt;
    fetch_packet_t          out_pkt;
    logic                   full;
    logic                   empty;
    logic                   enq;
    logic                   deq;

    assign in_pkt.instr          = i_instr;
    assign in_pkt.pc             = i_pc;
    assign in_pkt.guesses_branch = i_guesses_branch;
    assign in_pkt.prediction     = i_prediction;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Full blocks enqueue even with a simultaneous dequeue to keep o_ready shallow.
    assign o_ready = ~full & ~i_flush;

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass;

    assign bypass  = empty & i_valid & ~i_flush;
    assign o_valid = (~empty | i_valid) & ~i_flush;
    assign out_pkt = empty ? in_pkt : mem[rd_ptr];
    // A bypassed packet taken by the decoder never touches the array.
    assign enq     = i_valid & o_ready & ~(bypass & i_ready);
    assign deq     = o_valid & i_ready & ~bypass;
`else
    assign o_valid = ~empty & ~i_flush;
    assign out_pkt = mem[rd_ptr];
    assign enq     = i_valid & o_ready;
    assign deq     = o_valid & i_ready;
`endif

    assign o_instr          = out_pkt.instr;
    assign o_pc             = out_pkt.pc;
    assign o_guesses_branch = out_pkt.guesses_branch;
    assign o_prediction     = out_pkt.prediction;
    assign o_count          = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; enq already excludes flush cycles.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            mem[wr_ptr] <= in_pkt;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: handshake, full/wrap, flush and reset behaviour.
// Expectations follow the FETCH_BUFFER_BYPASS_EN setting of the build.
module tb_fetch_buffer;
   import riscv_core::*;

   localparam int AW = FETCH_ADDR_WIDTH;

   logic          clk;
   logic          reset;
   logic          i_flush;
   logic          i_valid;
   logic [31:0]   i_instr;
   logic [AW-1:0] i_pc;
   logic          i_guesses_branch;
   logic [AW-1:0] i_prediction;
   logic          o_ready;
   logic          o_valid;
   logic [31:0]   o_instr;
   logic [AW-1:0] o_pc;
   logic          o_guesses_branch;
   logic [AW-1:0] o_prediction;
   logic          i_ready;
   logic [3:0]    o_count;

   int n_checks = 0;
   int n_fail   = 0;
   int rx;
   bit done     = 1'b0;

   fetch_buffer dut (
      .clk              (clk),
      .reset            (reset),
      .i_flush          (i_flush),
      .i_valid          (i_valid),
      .i_instr          (i_instr),
      .i_pc             (i_pc),
      .i_guesses_branch (i_guesses_branch),
      .i_prediction     (i_prediction),
      .o_ready          (o_ready),
      .o_valid          (o_valid),
      .o_instr          (o_instr),
      .o_pc             (o_pc),
      .o_guesses_branch (o_guesses_branch),
      .o_prediction     (o_prediction),
      .i_ready          (i_ready),
      .o_count          (o_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      if (!done) begin
         n_fail++;
         $error("FAIL timeout: test did not complete within the wait limit");
         $finish;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic v, input int pc, input int instr,
                        input logic rdy, input logic fl, input logic rst);
      i_valid          = v;
      i_pc             = AW'(pc);
      i_instr          = instr;
      i_guesses_branch = pc[2];
      i_prediction     = AW'(pc + 4);
      i_ready          = rdy;
      i_flush          = fl;
      reset            = rst;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("reset_valid", o_valid, 1'b0);
      check("reset_ready", o_ready, 1'b1);
      check("reset_count", o_count, 4'd0);

      drive(1, 'h100, 'h00500093, 0, 0, 0);
`ifdef FETCH_BUFFER_BYPASS_EN
      check("push_bypass_valid", o_valid, 1'b1);
      check("push_bypass_pc", o_pc, AW'('h100));
`else
      check("push_same_cycle_valid", o_valid, 1'b0);
`endif
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("push_valid", o_valid, 1'b1);
      check("push_pc", o_pc, AW'('h100));
      check("push_instr", o_instr, 32'h00500093);
      check("push_pred", o_prediction, AW'('h104));
      check("push_count", o_count, 4'd1);
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("push_drained", o_count, 4'd0);
      check("push_drained_valid", o_valid, 1'b0);

      for (int k = 0; k < 8; k++) begin
         drive(1, 4 * k, 'h1000 + k, 0, 0, 0);
         tick();
      end
      drive(1, 'h20, 'h1008, 0, 0, 0);
      check("full_count", o_count, 4'd8);
      check("full_ready", o_ready, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("ninth_ignored_count", o_count, 4'd8);
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 1, 0, 0);
         check("drain_valid", o_valid, 1'b1);
         check("drain_pc", o_pc, AW'(4 * k));
         check("drain_instr", o_instr, 32'h1000 + k);
         check("drain_guess", o_guesses_branch, ((4 * k) & 4) != 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("drain_count", o_count, 4'd0);

      for (int k = 0; k < 8; k++) begin
         drive(1, 'h200 + 4 * k, 'h3000 + k, 0, 0, 0);
         tick();
      end
      drive(1, 'h300, 'h3100, 1, 0, 0);
      check("full_pushpop_ready", o_ready, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("full_pushpop_count", o_count, 4'd7);
      check("full_pushpop_ready_after", o_ready, 1'b1);
      for (int k = 1; k < 8; k++) begin
         drive(0, 0, 0, 1, 0, 0);
         check("pushpop_drain_pc", o_pc, AW'('h200 + 4 * k));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("pushpop_drain_count", o_count, 4'd0);

      rx = 0;
      for (int c = 0; c < 24; c++) begin
         if (c < 20) begin
            drive(1, 'h400 + 4 * c, 'h2000 + c, 1, 0, 0);
            check("stream_ready", o_ready, 1'b1);
         end else begin
            drive(0, 0, 0, 1, 0, 0);
         end
         if (o_valid) begin
            check("stream_pc", o_pc, AW'('h400 + 4 * rx));
            check("stream_instr", o_instr, 32'h2000 + rx);
            rx++;
         end
         tick();
`ifdef FETCH_BUFFER_BYPASS_EN
         check("stream_count_zero", o_count, 4'd0);
`else
         check("stream_count_le1", (o_count <= 4'd1), 1'b1);
`endif
      end
      drive(0, 0, 0, 0, 0, 0);
      check("stream_delivered", rx, 20);
      check("stream_final_count", o_count, 4'd0);

      for (int k = 0; k < 3; k++) begin
         drive(1, 'h500 + 4 * k, 'h4000 + k, 0, 0, 0);
         tick();
      end
      drive(1, 'h40, 'h4040, 0, 1, 0);
      check("flush_valid", o_valid, 1'b0);
      check("flush_ready", o_ready, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("flush_count", o_count, 4'd0);
      check("flush_valid_after", o_valid, 1'b0);
      drive(1, 'h600, 'h4600, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("post_flush_count", o_count, 4'd1);
      check("post_flush_pc", o_pc, AW'('h600));
      drive(0, 0, 0, 1, 0, 0);
      tick();

      for (int k = 0; k < 5; k++) begin
         drive(1, 'h700 + 4 * k, 'h5000 + k, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      check("pre_reset_count", o_count, 4'd5);
      drive(1, 'h714, 'h5005, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("mid_reset_valid", o_valid, 1'b0);
      check("mid_reset_ready", o_ready, 1'b1);
      check("mid_reset_count", o_count, 4'd0);
      drive(1, 'h800, 'h0000dead, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      check("post_reset_valid", o_valid, 1'b1);
      check("post_reset_pc", o_pc, AW'('h800));
      check("post_reset_instr", o_instr, 32'h0000dead);
      check("post_reset_count", o_count, 4'd1);

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
